mem_linebuf: RTL and testbench
==============================

// Module: mem_linebuf
// PURPOSE
//   Single-clock, parametrised multi-line buffer built from NUM_LINES inferred simple dual-port BRAM banks.
//   Stores the last NUM_LINES video lines and emits a vertical column of NUM_LINES+1 pixels per accepted pixel:
//   the current pixel plus the pixels directly above it. Sits between the pixel stream and 2D kernel stages
//   (e.g. 3x3 filters).
// PARAMETERS
//   DATA_WIDTH  12   bits per pixel
//   LINE_WIDTH  640  pixels per line; depth of each BRAM bank
//   NUM_LINES   2    stored lines (banks); number of taps = NUM_LINES+1; must be >= 1
// PORTS
//   i_clk      in   1                          single clock, all logic rising-edge
//   i_rst      in   1                          asynchronous, active-high reset
//   i_sof      in   1                          start of frame; qualifies the pixel (if any) on the same cycle
//   i_wvalid   in   1                          pixel valid; one pixel accepted per cycle when high (no backpressure)
//   i_wdata    in   DATA_WIDTH                 pixel data
//   o_tvalid   out  1                          tap column valid
//   o_taps     out  DATA_WIDTH*(NUM_LINES+1)   tap column; slice 0 (LSBs) = current line, slice k = k lines above
//   o_col      out  $clog2(LINE_WIDTH)         column index of the emitted tap column
//   o_eol      out  1                          high with o_tvalid when o_col == LINE_WIDTH-1
//   o_primed   out  1                          high once NUM_LINES full lines are stored since reset/SOF
// BEHAVIOUR
//   - Reset (async, i_rst=1): all outputs 0.
//     Internal state = 0: wcol, wbank, lines_filled.
//     BRAM contents are not cleared.
//   - Accept (i_wvalid=1): write i_wdata to bank wbank at address wcol.
//     On the same edge, read all banks at wcol, read-first.
//     Bank wbank therefore returns the oldest line before it is overwritten.
//   - Tap mapping:
//     - Slice 0 = i_wdata, registered.
//     - Slice k (1..NUM_LINES) = bank (wbank-k) mod NUM_LINES at wcol.
//     - Slice NUM_LINES is the read-first data of bank wbank.
//   - Latency: o_taps, o_col and o_eol are valid 1 cycle after the accepting edge.
//   - o_tvalid = i_wvalid delayed 1 cycle AND (lines_filled == NUM_LINES) at accept time.
//     o_taps/o_col may change while o_tvalid=0 and are don't-care then.
//   - Counters on accept:
//     - wcol increments.
//     - At wcol == LINE_WIDTH-1: wcol wraps to 0 and wbank advances mod NUM_LINES.
//     - lines_filled increments on that wrap and saturates at NUM_LINES.
//   - o_primed = (lines_filled == NUM_LINES), registered.
//   - No accept (i_wvalid=0): counters hold; o_tvalid=0 next cycle; other outputs hold.
//   - i_sof=1: wcol, wbank and lines_filled are forced to 0 before the accept decision.
//     - With i_wvalid=1: the pixel is written to bank 0, column 0, and wcol becomes 1.
//       The emitted column is not valid (lines_filled=0).
//     - With i_wvalid=0: counters clear and nothing is written.
//     - Mid-line SOF discards the partial line and all stored lines logically; o_primed drops next cycle.
//   - Line length is fixed by LINE_WIDTH. There is no EOL input; a short line desynchronises until the next SOF.
//   - Reset mid-operation: effect is immediate. The first post-reset pixel behaves as if SOF were asserted.
//   - Widths:
//     - wbank is $clog2(NUM_LINES) bits, minimum 1.
//     - Modular bank arithmetic must be correct for non-power-of-2 NUM_LINES (explicit wrap, not truncation).
// TESTING
//   (DATA_WIDTH=12, LINE_WIDTH=8, NUM_LINES=2; pixel(l,c) = l*16+c, streamed with i_sof on (0,0).)
//   1. Async reset asserted between edges -> all outputs 0 immediately; held 0 until first accept.
//   2. Stream lines 0-1 -> o_tvalid never high; o_primed rises the cycle after pixel (1,7) is accepted.
//   3. Accept (2,0) -> next cycle o_tvalid=1, o_col=0, o_taps={12'h000,12'h010,12'h020} (MSB..LSB).
//      Accept (2,7) -> o_eol=1.
//   4. Line 3, col 5 (bank rotation/wrap) -> o_taps={12'h015,12'h025,12'h035}.
//   5. Gapped stream: i_wvalid toggles 1/0 during line 3 -> o_tvalid follows with 1-cycle lag; o_col strictly +1 per valid.
//      Taps identical to the gap-free run.
//   6. i_sof at (4,3) with i_wvalid=1 -> o_primed falls; no o_tvalid for the next 16 accepts.
//      The 17th accept yields taps {new (0,0), new (1,0), new (2,0)}.
//   7. NUM_LINES=3 build, 4 lines streamed -> line 3 col 2 gives {12'h002,12'h012,12'h022,12'h032}.

Source files
------------

// File: rtl/mem_linebuf.sv
// Multi-line video buffer: NUM_LINES simple dual-port BRAM banks emit a vertical column of
// NUM_LINES+1 pixels (current pixel plus the pixels directly above it) per accepted pixel.
module mem_linebuf #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned LINE_WIDTH = 640,
    parameter int unsigned NUM_LINES  = 2
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_sof,
    input  logic                                i_wvalid,
    input  logic [DATA_WIDTH-1:0]               i_wdata,
    output logic                                o_tvalid,
    output logic [DATA_WIDTH*(NUM_LINES+1)-1:0] o_taps,
    output logic [$clog2(LINE_WIDTH)-1:0]       o_col,
    output logic                                o_eol,
    output logic                                o_primed
);
    localparam int unsigned CW = $clog2(LINE_WIDTH);
    localparam int unsigned BW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int unsigned FW = $clog2(NUM_LINES + 1);
    localparam int unsigned TW = DATA_WIDTH * (NUM_LINES + 1);
    localparam logic [CW-1:0] LastCol  = CW'(LINE_WIDTH - 1);
    localparam logic [BW-1:0] LastBank = BW'(NUM_LINES - 1);
    localparam logic [FW-1:0] Full     = FW'(NUM_LINES);

    logic [CW-1:0] r_wcol, r_ocol;
    logic [BW-1:0] r_wbank, r_tbank;
    logic [FW-1:0] r_filled;
    logic          r_tvalid, r_eol, r_primed;
    logic [DATA_WIDTH-1:0] r_pix;

    logic [CW-1:0] w_col, w_col_nxt;
    logic [BW-1:0] w_bank, w_bank_nxt;
    logic [FW-1:0] w_fill, w_fill_nxt;
    logic          w_last;
    logic [DATA_WIDTH-1:0] w_rd [NUM_LINES];
    logic [TW-1:0] w_taps;

    // SOF clears the write position before the accept decision is made
    assign w_col  = i_sof ? '0 : r_wcol;
    assign w_bank = i_sof ? '0 : r_wbank;
    assign w_fill = i_sof ? '0 : r_filled;
    assign w_last = (w_col == LastCol);

    always_comb begin
        w_col_nxt  = w_col;
        w_bank_nxt = w_bank;
        w_fill_nxt = w_fill;
        if (i_wvalid) begin
            if (w_last) begin
                w_col_nxt  = '0;
                w_bank_nxt = (w_bank == LastBank) ? '0 : w_bank + 1'b1;
                w_fill_nxt = (w_fill == Full) ? w_fill : w_fill + 1'b1;
            end else begin
                w_col_nxt = w_col + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wcol   <= '0;
            r_wbank  <= '0;
            r_filled <= '0;
            r_tvalid <= 1'b0;
            r_eol    <= 1'b0;
            r_primed <= 1'b0;
            r_ocol   <= '0;
            r_tbank  <= '0;
            r_pix    <= '0;
        end else begin
            r_wcol   <= w_col_nxt;
            r_wbank  <= w_bank_nxt;
            r_filled <= w_fill_nxt;
            r_primed <= (w_fill_nxt == Full);
            r_tvalid <= i_wvalid && (w_fill == Full);
            r_eol    <= i_wvalid && (w_fill == Full) && w_last;
            if (i_wvalid) begin
                r_ocol  <= w_col;
                r_tbank <= w_bank;
                r_pix   <= i_wdata;
            end
        end
    end

    for (genvar b = 0; b < NUM_LINES; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_mem [LINE_WIDTH];
        logic [DATA_WIDTH-1:0] r_rd;

        always_ff @(posedge i_clk) begin
            if (i_wvalid && (w_bank == BW'(b))) begin
                r_mem[w_col] <= i_wdata;
            end
        end

        // Read-first: the bank being written returns the oldest stored line
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_rd <= '0;
            end else if (i_wvalid) begin
                r_rd <= r_mem[w_col];
            end
        end

        assign w_rd[b] = r_rd;
    end

    // Slice k comes from bank (tbank - k) mod NUM_LINES; one conditional subtract suffices
    always_comb begin
        int unsigned v_idx;
        logic [BW-1:0] v_sel;
        w_taps = '0;
        w_taps[DATA_WIDTH-1:0] = r_pix;
        for (int unsigned k = 1; k <= NUM_LINES; k++) begin
            v_idx = int'(r_tbank) + NUM_LINES - k;
            if (v_idx >= NUM_LINES) begin
                v_idx = v_idx - NUM_LINES;
            end
            v_sel = BW'(v_idx);
            w_taps[k*DATA_WIDTH +: DATA_WIDTH] = w_rd[v_sel];
        end
    end

    assign o_taps   = w_taps;
    assign o_tvalid = r_tvalid;
    assign o_col    = r_ocol;
    assign o_eol    = r_eol;
    assign o_primed = r_primed;
endmodule

// File: tb/tb_mem_linebuf.sv
// Randomized bench for mem_linebuf: a 2-line and a 3-line build share one pixel stream and are
// checked against a frame-history model indexed by logical line and column.
module tb_mem_linebuf;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_sof = 1'b0;
    logic i_wvalid = 1'b0;
    logic [11:0] i_wdata = '0;

    logic        tv2, eol2, pr2, tv3, eol3, pr3;
    logic [35:0] taps2;
    logic [47:0] taps3;
    logic [2:0]  col2, col3;

    int n_total = 0;
    int n_bad = 0;

    // Model: pixels of the current frame by logical line (mod 64) and column
    logic [11:0] hist [64][LW];
    int ml = 0;
    int mc = 0;

    always #5 clk = ~clk;

    mem_linebuf #(.DATA_WIDTH(12), .LINE_WIDTH(LW), .NUM_LINES(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_sof(i_sof), .i_wvalid(i_wvalid), .i_wdata(i_wdata),
        .o_tvalid(tv2), .o_taps(taps2), .o_col(col2), .o_eol(eol2), .o_primed(pr2)
    );

    mem_linebuf #(.DATA_WIDTH(12), .LINE_WIDTH(LW), .NUM_LINES(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_sof(i_sof), .i_wvalid(i_wvalid), .i_wdata(i_wdata),
        .o_tvalid(tv3), .o_taps(taps3), .o_col(col3), .o_eol(eol3), .o_primed(pr3)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_taps(input int n, input logic [11:0] d);
        logic [63:0] r;
        r = '0;
        r[11:0] = d;
        for (int k = 1; k <= n; k++) begin
            r[k*12 +: 12] = hist[(ml - k) & 63][mc];
        end
        return r;
    endfunction

    task automatic check_zero(input string tag);
        check_eq({tag, "_out2"}, {26'h0, tv2, eol2, pr2, col2, taps2}, 64'h0);
        check_eq({tag, "_out3"}, {9'h0, tv3, eol3, pr3, col3, taps3}, 64'h0);
    endtask

    task automatic step(input logic sof, input logic vld, input logic [11:0] d);
        logic [63:0] e2, e3;
        logic v2, v3;
        int ccol;
        i_sof = sof;
        i_wvalid = vld;
        i_wdata = d;
        if (sof) begin
            ml = 0;
            mc = 0;
        end
        v2 = vld && (ml >= 2);
        v3 = vld && (ml >= 3);
        e2 = exp_taps(2, d);
        e3 = exp_taps(3, d);
        ccol = mc;
        if (vld) begin
            hist[ml & 63][mc] = d;
            mc++;
            if (mc == LW) begin
                mc = 0;
                ml++;
            end
        end
        @(posedge clk);
        #1;
        i_sof = 1'b0;
        i_wvalid = 1'b0;
        check_eq("tvalid2", 64'(tv2), 64'(v2));
        check_eq("tvalid3", 64'(tv3), 64'(v3));
        check_eq("primed2", 64'(pr2), 64'(ml >= 2));
        check_eq("primed3", 64'(pr3), 64'(ml >= 3));
        if (v2) begin
            check_eq("taps2", 64'(taps2), e2);
            check_eq("col2", 64'(col2), 64'(ccol));
            check_eq("eol2", 64'(eol2), 64'(ccol == LW - 1));
        end
        if (v3) begin
            check_eq("taps3", 64'(taps3), e3);
            check_eq("col3", 64'(col3), 64'(ccol));
            check_eq("eol3", 64'(eol3), 64'(ccol == LW - 1));
        end
    endtask

    initial begin
        // Reset held from time 0: outputs must read zero before release and until first accept
        #2;
        check_zero("rst_init");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_zero("rst_release");
        step(1'b0, 1'b0, 12'h0);

        // Deterministic frame, pixel(l,c) = l*16+c, line 3 gapped
        for (int l = 0; l < 4; l++) begin
            for (int c = 0; c < LW; c++) begin
                step((l == 0 && c == 0), 1'b1, 12'(l * 16 + c));
                if (l == 2 && c == 0) check_eq("t3_taps", 64'(taps2), 64'h000010020);
                if (l == 2 && c == 7) check_eq("t3_eol", 64'(eol2), 64'h1);
                if (l == 3 && c == 5) check_eq("t4_taps", 64'(taps2), 64'h015025035);
                if (l == 3 && c == 2) check_eq("t7_taps", 64'(taps3), 64'h002012022032);
                if (l == 3 && c[0]) step(1'b0, 1'b0, 12'hfff);
            end
        end
        for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 12'(64 + c));

        // Mid-line SOF: new frame data 0x100 + l*16 + c
        for (int i = 0; i < 17; i++) begin
            step((i == 0), 1'b1, 12'(256 + (i / LW) * 16 + (i % LW)));
        end
        check_eq("t6_taps", 64'(taps2), 64'h100110120);

        // Randomized traffic with occasional SOF and one asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #2;
                rst = 1'b1;
                #1;
                check_zero("rst_mid");
                ml = 0;
                mc = 0;
                @(posedge clk);
                #3;
                rst = 1'b0;
                #1;
                check_zero("rst_mid_rel");
            end
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0),
                 12'($urandom_range(0, 4095)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
